wb_wakeup_arbiter: RTL and testbench
====================================

// Module: wb_wakeup_arbiter
// PURPOSE
//  Shares the busy table's two free/wakeup write ports between NUM_REQ writeback requesters (ALU0, ALU1, MUL/DIV, LSU).
//  Each cycle, up to two requests are granted in round-robin order.
//  Granted prd tags are driven onto registered free_en0/1, free_addr0/1, which connect straight to the busy table.
//  Sits between the execution-unit writeback stage and dispatch; all requests are squashed during ROB RAT overwrite.
// PARAMETERS
//  NUM_REQ    4                 number of writeback requesters (>=2)
//  PREG_W     width of `PREG_RANGE  physical register tag width
// PORTS
//  clock        in   1                clock
//  reset_n      in   1                asynchronous, active-low reset
//  rob_state    in   2                ROB state (`ROB_STATE_IDLE/_OVERWRITE_RAT/_WALKING)
//  req_valid    in   NUM_REQ          requester i has a prd to wake up
//  req_prd      in   NUM_REQ*PREG_W   prd of requester i, packed [i*PREG_W +: PREG_W]
//  req_ready    out  NUM_REQ          combinational grant; transfer when valid&ready
//  free_en0     out  1                busy-table free port 0 enable (registered)
//  free_addr0   out  PREG_W           busy-table free port 0 prd (registered)
//  free_en1     out  1                busy-table free port 1 enable (registered)
//  free_addr1   out  PREG_W           busy-table free port 1 prd (registered)
//  rr_ptr_o     out  log2(NUM_REQ)    current round-robin pointer (debug/verif)
// BEHAVIOUR
//  - Reset (async): free_en0/1=0, free_addr0/1=0, rr_ptr=0. req_ready is combinational, so it is 0 while reset_n=0.
//  - Handshake: a requester holds valid and prd stable until it sees ready. A dropped valid without ready is
//    legal; the request is simply lost.
//  - Arbitration (combinational): scan i = rr_ptr, rr_ptr+1, ... mod NUM_REQ.
//    - First valid requester -> slot0. Second valid requester -> slot1.
//    - Only granted requesters get req_ready=1; at most 2 ready bits are high per cycle.
//  - Single grant: it always occupies slot0; slot1 stays idle (free_en1=0 next cycle).
//  - Latency: grant in cycle N -> free_en/addr valid in cycle N+1 for exactly one cycle. Outputs are never held.
//  - Pointer update on any grant: rr_ptr <= (index of last granted requester + 1) mod NUM_REQ.
//    With no grant, rr_ptr holds. Wrap from NUM_REQ-1 to 0 is modular.
//  - Duplicate prd in both slots is legal; both ports are driven (the free is idempotent at the busy table).
//  - rob_state==OVERWRITE_RAT:
//    - all req_ready=0; no grants.
//    - free_en0/1 <= 0 at the next edge, even if a grant was pending from the prior cycle
//      (the outputs registered in that cycle are still presented once).
//    - rr_ptr <= 0.
//  - rob_state==WALKING or IDLE: normal arbitration.
//  - Starvation bound: a continuously valid requester is granted within ceil(NUM_REQ/2) cycles.
//  - Async reset mid-operation clears outputs and pointer immediately. Requests in flight are lost;
//    requesters re-present them after reset.
//  - free_addrX takes the granted prd when free_enX is set. Otherwise the address holds its previous value
//    (don't-care, no toggle required).
// TESTING
//  1. Reset: reset_n=0 with all req_valid=1 -> req_ready=0000, free_en0/1=0, rr_ptr_o=0.
//  2. Full contention, ptr=0, all valid, prd={i0:5, i1:9, i2:12, i3:20}:
//     - cycle N: ready=0011; N+1: en0/addr0=5, en1/addr1=9, ptr=2.
//     - cycle N+1: ready=1100; N+2: addrs 12, 20, ptr=0.
//  3. Single request: only req3 valid, prd=7, ptr=1 -> ready=1000; next cycle en0=1, addr0=7, en1=0, ptr=0 (wrap).
//  4. Overwrite flush: grant in cycle N, then rob_state=OVERWRITE in N+1 with all valid:
//     - N+1: ready=0, free outputs from N presented.
//     - N+2: en0/1=0, ptr=0.
//  5. Duplicate prd: req0 and req1 both valid with prd=33 -> next cycle en0=en1=1, addr0=addr1=33.
//  6. Fairness: req0..3 held valid for 40 random cycles -> no requester waits >2 cycles;
//     grant counts differ by <=1.

Source files
------------

// File: rtl/wb_wakeup_arbiter_if.sv
// Writeback wakeup bus between the execution-unit requesters and the
// busy-table free ports.
//   req_valid  : requester i has a prd to wake up
//   req_prd    : prd of requester i, packed [i*PREG_W +: PREG_W]
//   req_ready  : grant back to requester i (transfer on valid & ready)
//   free_en0/1, free_addr0/1 : registered busy-table free ports
// Modports: master = requester/busy-table side, slave = arbiter.
interface wb_wakeup_arbiter_if #(
    parameter int NUM_REQ = 4,
    parameter int PREG_W  = 7
);
    logic [NUM_REQ-1:0]        req_valid;
    logic [NUM_REQ*PREG_W-1:0] req_prd;
    logic [NUM_REQ-1:0]        req_ready;
    logic                      free_en0;
    logic [PREG_W-1:0]         free_addr0;
    logic                      free_en1;
    logic [PREG_W-1:0]         free_addr1;

    modport master (
        output req_valid, req_prd,
        input  req_ready, free_en0, free_addr0, free_en1, free_addr1
    );

    modport slave (
        input  req_valid, req_prd,
        output req_ready, free_en0, free_addr0, free_en1, free_addr1
    );
endinterface

// File: rtl/wb_wakeup_arbiter.sv
// Round-robin arbiter sharing the busy table's two free/wakeup write ports
// among NUM_REQ writeback requesters. Up to two grants per cycle; the first
// valid requester found from rr_ptr goes to slot0, the second to slot1.
// Granted prds appear on the registered free ports one cycle later.
// All grants are squashed while the ROB overwrites the RAT.
// Ports:
//   clock, reset_n : clock, asynchronous active-low reset
//   rob_state      : ROB state; only OVERWRITE_RAT changes behaviour
//   bus            : requester handshake + busy-table free ports (slave)
//   rr_ptr_o       : current round-robin pointer
module wb_wakeup_arbiter #(
    parameter int         NUM_REQ                 = 4,
    parameter int         PREG_W                  = 7,
    parameter logic [1:0] ROB_STATE_OVERWRITE_RAT = 2'd1,
    localparam int        PTR_W                   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic [1:0]        rob_state,
    wb_wakeup_arbiter_if.slave bus,
    output logic [PTR_W-1:0]  rr_ptr_o
);
    localparam logic [PTR_W:0] NUM_REQ_W = (PTR_W+1)'(NUM_REQ);

    logic [NUM_REQ-1:0][PREG_W-1:0] prd_a;
    logic [NUM_REQ-1:0]             ready;
    logic                           grant0, grant1;
    logic [PTR_W-1:0]               sel0, sel1, last, idx;
    logic [PTR_W:0]                 sum, nxt;

    logic              free_en0_q, free_en0_d, free_en1_q, free_en1_d;
    logic [PREG_W-1:0] free_addr0_q, free_addr0_d, free_addr1_q, free_addr1_d;
    logic [PTR_W-1:0]  rr_ptr_q, rr_ptr_d;

    assign prd_a = bus.req_prd;

    always_comb begin
        grant0       = 1'b0;
        grant1       = 1'b0;
        sel0         = '0;
        sel1         = '0;
        last         = '0;
        idx          = '0;
        sum          = '0;
        nxt          = '0;
        ready        = '0;
        free_en0_d   = 1'b0;
        free_en1_d   = 1'b0;
        free_addr0_d = free_addr0_q;
        free_addr1_d = free_addr1_q;
        rr_ptr_d     = rr_ptr_q;

        if (rob_state == ROB_STATE_OVERWRITE_RAT) begin
            // Flush: no grants; already-registered frees still present once.
            rr_ptr_d = '0;
        end else begin
            // Rotational scan starting at rr_ptr; stop filling after two.
            for (int k = 0; k < NUM_REQ; k++) begin
                sum = {1'b0, rr_ptr_q} + (PTR_W+1)'(k);
                if (sum >= NUM_REQ_W) sum = sum - NUM_REQ_W;
                idx = sum[PTR_W-1:0];
                if (bus.req_valid[idx] && !grant1) begin
                    if (!grant0) begin
                        grant0 = 1'b1;
                        sel0   = idx;
                    end else begin
                        grant1 = 1'b1;
                        sel1   = idx;
                    end
                end
            end

            if (grant0) begin
                ready[sel0]  = 1'b1;
                free_en0_d   = 1'b1;
                free_addr0_d = prd_a[sel0];
                last         = sel0;
            end
            if (grant1) begin
                ready[sel1]  = 1'b1;
                free_en1_d   = 1'b1;
                free_addr1_d = prd_a[sel1];
                last         = sel1;
            end
            // Next scan starts just past the last requester served.
            if (grant0) begin
                nxt = {1'b0, last} + (PTR_W+1)'(1);
                if (nxt >= NUM_REQ_W) nxt = nxt - NUM_REQ_W;
                rr_ptr_d = nxt[PTR_W-1:0];
            end
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            free_en0_q   <= 1'b0;
            free_en1_q   <= 1'b0;
            free_addr0_q <= '0;
            free_addr1_q <= '0;
            rr_ptr_q     <= '0;
        end else begin
            free_en0_q   <= free_en0_d;
            free_en1_q   <= free_en1_d;
            free_addr0_q <= free_addr0_d;
            free_addr1_q <= free_addr1_d;
            rr_ptr_q     <= rr_ptr_d;
        end
    end

    // Grants are combinational; hold them low while in reset.
    assign bus.req_ready  = ready & {NUM_REQ{reset_n}};
    assign bus.free_en0   = free_en0_q;
    assign bus.free_addr0 = free_addr0_q;
    assign bus.free_en1   = free_en1_q;
    assign bus.free_addr1 = free_addr1_q;
    assign rr_ptr_o       = rr_ptr_q;
endmodule

// File: tb/tb_wb_wakeup_arbiter.sv
module tb_wb_wakeup_arbiter;
    localparam int NUM_REQ = 4;
    localparam int PREG_W  = 7;
    localparam logic [1:0] IDLE = 2'd0, OVR = 2'd1, WALK = 2'd2;

    logic       clock = 1'b0;
    logic       reset_n = 1'b0;
    logic [1:0] rob_state = IDLE;
    logic [1:0] rr_ptr_o;

    wb_wakeup_arbiter_if #(.NUM_REQ(NUM_REQ), .PREG_W(PREG_W)) bus ();

    wb_wakeup_arbiter #(.NUM_REQ(NUM_REQ), .PREG_W(PREG_W)) dut (
        .clock     (clock),
        .reset_n   (reset_n),
        .rob_state (rob_state),
        .bus       (bus),
        .rr_ptr_o  (rr_ptr_o)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [1:0]                     rob;
        logic [3:0]                     valid;
        logic [NUM_REQ-1:0][PREG_W-1:0] prd;
        logic [3:0]                     ready;
        logic                           en0;
        logic [PREG_W-1:0]              a0;
        logic                           en1;
        logic [PREG_W-1:0]              a1;
        logic [1:0]                     ptr;
    } vec_t;

    vec_t tbl[11];
    int   errs = 0;
    int   checks = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic [1:0] rob, input logic [3:0] valid,
                                input int p0, input int p1, input int p2, input int p3,
                                input logic [3:0] ready, input logic en0, input int a0,
                                input logic en1, input int a1, input int ptr);
        vec_t v;
        v.rob = rob; v.valid = valid;
        v.prd[0] = PREG_W'(p0); v.prd[1] = PREG_W'(p1);
        v.prd[2] = PREG_W'(p2); v.prd[3] = PREG_W'(p3);
        v.ready = ready; v.en0 = en0; v.a0 = PREG_W'(a0);
        v.en1 = en1; v.a1 = PREG_W'(a1); v.ptr = 2'(ptr);
        return v;
    endfunction

    task automatic drive(input logic [1:0] rob, input logic [3:0] valid,
                         input logic [NUM_REQ-1:0][PREG_W-1:0] prd);
        rob_state     = rob;
        bus.req_valid = valid;
        bus.req_prd   = prd;
    endtask

    logic [NUM_REQ-1:0][PREG_W-1:0] p;
    logic [NUM_REQ-1:0][PREG_W-1:0] p_prev;
    logic [3:0] r;
    int gcnt[4];
    int waitc[4];
    int maxw, x, gmin, gmax;

    initial begin
        // table: ptr 0 after reset; each row's expectation follows from the previous row
        tbl[0]  = mk(IDLE, 4'b1111,  5,  9, 12, 20, 4'b0011, 1,  5, 1,  9, 2);
        tbl[1]  = mk(IDLE, 4'b1111,  5,  9, 12, 20, 4'b1100, 1, 12, 1, 20, 0);
        tbl[2]  = mk(IDLE, 4'b0001, 11,  0,  0,  0, 4'b0001, 1, 11, 0, 20, 1);
        tbl[3]  = mk(IDLE, 4'b1000,  0,  0,  0,  7, 4'b1000, 1,  7, 0, 20, 0);
        tbl[4]  = mk(IDLE, 4'b0011, 33, 33,  0,  0, 4'b0011, 1, 33, 1, 33, 2);
        tbl[5]  = mk(IDLE, 4'b0000,  1,  1,  1,  1, 4'b0000, 0, 33, 0, 33, 2);
        tbl[6]  = mk(IDLE, 4'b0101,  2,  0, 40,  0, 4'b0101, 1, 40, 1,  2, 1);
        tbl[7]  = mk(OVR,  4'b1111,  3,  4,  5,  6, 4'b0000, 0, 40, 0,  2, 0);
        tbl[8]  = mk(IDLE, 4'b1010,  0, 17,  0, 50, 4'b1010, 1, 17, 1, 50, 0);
        tbl[9]  = mk(WALK, 4'b0110,  0,  1,  2,  0, 4'b0110, 1,  1, 1,  2, 3);
        tbl[10] = mk(IDLE, 4'b1001, 61,  0,  0, 60, 4'b1001, 1, 60, 1, 61, 1);

        // reset with every requester asserting
        p = '0;
        drive(IDLE, 4'b1111, p);
        #3;
        chk("rst_ready", 32'(bus.req_ready), 0);
        chk("rst_en0",   32'(bus.free_en0), 0);
        chk("rst_en1",   32'(bus.free_en1), 0);
        chk("rst_ptr",   32'(rr_ptr_o), 0);
        @(posedge clock); #1;
        reset_n = 1'b1;

        foreach (tbl[i]) begin
            drive(tbl[i].rob, tbl[i].valid, tbl[i].prd);
            #2;
            chk($sformatf("v%0d_ready", i), 32'(bus.req_ready), 32'(tbl[i].ready));
            @(posedge clock); #1;
            chk($sformatf("v%0d_en0", i),  32'(bus.free_en0),   32'(tbl[i].en0));
            chk($sformatf("v%0d_addr0", i), 32'(bus.free_addr0), 32'(tbl[i].a0));
            chk($sformatf("v%0d_en1", i),  32'(bus.free_en1),   32'(tbl[i].en1));
            chk($sformatf("v%0d_addr1", i), 32'(bus.free_addr1), 32'(tbl[i].a1));
            chk($sformatf("v%0d_ptr", i),  32'(rr_ptr_o),       32'(tbl[i].ptr));
        end

        // overwrite flush with a grant pending from the previous cycle (ptr=1)
        p[0] = 7'd5; p[1] = 7'd9; p[2] = 7'd12; p[3] = 7'd20;
        drive(IDLE, 4'b1111, p);
        #2;
        chk("ovr_pre_ready", 32'(bus.req_ready), 32'b0110);
        @(posedge clock); #1;
        drive(OVR, 4'b1111, p);
        #2;
        chk("ovr_ready",  32'(bus.req_ready), 0);
        chk("ovr_en0",    32'(bus.free_en0), 1);
        chk("ovr_addr0",  32'(bus.free_addr0), 9);
        chk("ovr_en1",    32'(bus.free_en1), 1);
        chk("ovr_addr1",  32'(bus.free_addr1), 12);
        @(posedge clock); #1;
        chk("ovr_flush_en0", 32'(bus.free_en0), 0);
        chk("ovr_flush_en1", 32'(bus.free_en1), 0);
        chk("ovr_flush_ptr", 32'(rr_ptr_o), 0);

        // asynchronous reset in the middle of a cycle with outputs active
        drive(IDLE, 4'b1111, p);
        @(posedge clock); #1;
        chk("mid_pre_en0", 32'(bus.free_en0), 1);
        chk("mid_pre_ptr", 32'(rr_ptr_o), 2);
        #2 reset_n = 1'b0;
        #1;
        chk("mid_en0",   32'(bus.free_en0), 0);
        chk("mid_en1",   32'(bus.free_en1), 0);
        chk("mid_addr0", 32'(bus.free_addr0), 0);
        chk("mid_ptr",   32'(rr_ptr_o), 0);
        chk("mid_ready", 32'(bus.req_ready), 0);
        @(posedge clock); #1;
        reset_n = 1'b1;

        // fairness: all requesters valid for 40 cycles with random prds
        for (int i = 0; i < 4; i++) begin gcnt[i] = 0; waitc[i] = 0; end
        for (int c = 0; c < 40; c++) begin
            for (int i = 0; i < 4; i++) p[i] = PREG_W'($urandom_range(0, 127));
            drive(IDLE, 4'b1111, p);
            #2;
            r = bus.req_ready;
            chk($sformatf("fair_pair_c%0d", c), 32'($countones(r)), 2);
            maxw = 0;
            x = 0;
            for (int i = 0; i < 4; i++) begin
                if (r[i]) begin
                    gcnt[i]++;
                    waitc[i] = 0;
                    if (!r[(i + 3) % 4]) x = i;
                end else begin
                    waitc[i]++;
                end
                if (waitc[i] > maxw) maxw = waitc[i];
            end
            checks++;
            if (maxw > 1) begin
                errs++;
                $display("FAIL fair_wait_c%0d: got %0d idle cycles expected at most 1", c, maxw);
            end
            p_prev = p;
            @(posedge clock); #1;
            chk($sformatf("fair_addr0_c%0d", c), 32'(bus.free_addr0), 32'(p_prev[x]));
            chk($sformatf("fair_addr1_c%0d", c), 32'(bus.free_addr1), 32'(p_prev[(x + 1) % 4]));
        end
        gmin = gcnt[0]; gmax = gcnt[0];
        for (int i = 1; i < 4; i++) begin
            if (gcnt[i] < gmin) gmin = gcnt[i];
            if (gcnt[i] > gmax) gmax = gcnt[i];
        end
        checks++;
        if (gmax - gmin > 1) begin
            errs++;
            $display("FAIL fair_count: got spread %0d expected at most 1", gmax - gmin);
        end
        chk("fair_total", 32'(gcnt[0] + gcnt[1] + gcnt[2] + gcnt[3]), 80);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule
